// File: rtl/data_serialize_if.sv
// -----------------------------------------------------------------------------
// data_serialize_if
// Bundles the upstream valid/ready word handshake and the downstream FIFO
// write port of the data_serialize block.
//
// Signals
//   data_in    wide word offered by upstream (sampled only on accept)
//   data_valid upstream word present
//   data_ready serializer can take a word
//   buf_full   downstream FIFO cannot take a symbol this cycle
//   wr_en      write strobe into the FIFO, qualifies data_out
//   data_out   current narrow symbol
//   busy       a word is being serialized
//   done       one-cycle pulse after the last symbol of a word was written
//
// Modports
//   master  the environment: drives the word, valid and FIFO-full status
//   slave   the serializer: drives ready, write strobe, symbol and status
// -----------------------------------------------------------------------------
interface data_serialize_if #(
  parameter int IN_WIDTH  = 252,
  parameter int OUT_WIDTH = 4
);
  logic [IN_WIDTH-1:0]  data_in;
  logic                 data_valid;
  logic                 data_ready;
  logic                 buf_full;
  logic                 wr_en;
  logic [OUT_WIDTH-1:0] data_out;
  logic                 busy;
  logic                 done;

  modport master (
    output data_in,
    output data_valid,
    output buf_full,
    input  data_ready,
    input  wr_en,
    input  data_out,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  buf_full,
    output data_ready,
    output wr_en,
    output data_out,
    output busy,
    output done
  );
endinterface

// File: rtl/data_serialize.sv
// -----------------------------------------------------------------------------
// data_serialize
// Unpacks one IN_WIDTH-bit word into IN_WIDTH/OUT_WIDTH symbols of OUT_WIDTH
// bits and writes them, most significant symbol first, into a downstream FIFO.
// This undoes the symbol packer that fills the MSBs of a word with the first
// received symbol, so the original stream order is restored.
//
// Ports
//   clk   single clock, everything changes on its rising edge
//   rst   synchronous active-high reset
//   bus   data_serialize_if.slave:
//           data_in/data_valid/data_ready  upstream word handshake
//           buf_full/wr_en/data_out        downstream FIFO write port
//           busy                           word in flight
//           done                           pulse after the last symbol
//
// IN_WIDTH must be an integer multiple of OUT_WIDTH.
// -----------------------------------------------------------------------------
module data_serialize #(
  parameter int IN_WIDTH  = 252,
  parameter int OUT_WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  data_serialize_if.slave bus
);

  localparam int SYM_NUM = IN_WIDTH / OUT_WIDTH;
  // Keep the counter at least one bit wide even for a single-symbol word.
  localparam int CNT_W = (SYM_NUM > 1) ? $clog2(SYM_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYM_NUM - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              state_r;
  logic [IN_WIDTH-1:0] shift_reg_r;
  logic [CNT_W-1:0]    sym_cnt_r;
  logic                done_r;

  logic                wr_en_s;
  logic                data_ready_s;
  logic                accept_s;
  logic                last_sym_s;

  // Handshake decode: reset forces both strobes low before the state settles.
  always_comb begin
    wr_en_s      = 1'b0;
    data_ready_s = 1'b0;
    if (rst) begin
      wr_en_s      = 1'b0;
      data_ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          data_ready_s = 1'b1;
          wr_en_s      = 1'b0;
        end
        ST_SHIFT: begin
          data_ready_s = 1'b0;
          wr_en_s      = !bus.buf_full;
        end
        default: begin
          data_ready_s = 1'b0;
          wr_en_s      = 1'b0;
        end
      endcase
    end
  end

  assign accept_s   = data_ready_s & bus.data_valid;
  assign last_sym_s = (sym_cnt_r == LAST_CNT);

  // Serializer FSM: loads a word on accept, shifts one symbol per FIFO write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shift_reg_r <= {IN_WIDTH{1'b0}};
      sym_cnt_r   <= {CNT_W{1'b0}};
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            shift_reg_r <= bus.data_in;
            sym_cnt_r   <= {CNT_W{1'b0}};
            state_r     <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // A stalled FIFO simply freezes the word; nothing is lost or repeated.
          if (wr_en_s) begin
            // Zero fill leaves data_out at 0 once the word is exhausted.
            shift_reg_r <= shift_reg_r << OUT_WIDTH;
            if (last_sym_s) begin
              sym_cnt_r <= {CNT_W{1'b0}};
              state_r   <= ST_IDLE;
              done_r    <= 1'b1;
            end else begin
              sym_cnt_r <= sym_cnt_r + CNT_W'(1);
              state_r   <= ST_SHIFT;
            end
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          shift_reg_r <= {IN_WIDTH{1'b0}};
          sym_cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.data_ready = data_ready_s;
  assign bus.wr_en      = wr_en_s;
  assign bus.data_out   = shift_reg_r[IN_WIDTH-1 -: OUT_WIDTH];
  assign bus.busy       = (state_r == ST_SHIFT);
  assign bus.done       = done_r;

endmodule

// File: tb/tb_data_serialize.sv
// -----------------------------------------------------------------------------
// tb_data_serialize
// Drives data_serialize through directed scenarios and a random phase. A
// reference model holds the pending symbols of the current word in a queue:
// a word is split MSB-first on accept, one symbol leaves per write, and an
// empty queue after a write means a done pulse next cycle.
// -----------------------------------------------------------------------------
module tb_data_serialize;

  localparam int IN_W  = 252;
  localparam int OUT_W = 4;
  localparam int SYM_N = IN_W / OUT_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  data_serialize_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

  data_serialize #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [OUT_W-1:0] m_q[$];
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  bit   chk_en = 1'b0;

  // bookkeeping
  int cyc      = 0;
  int acc_cyc  = -1;
  int done_cyc = -1;
  int acc_cnt  = 0;
  int obs_wr   = 0;
  int obs_done = 0;
  bit seen_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w = (w << 32) | IN_W'($urandom());
    return w;
  endfunction

  // symbol k (k = 0 first out) = k mod 16
  function automatic logic [IN_W-1:0] ramp_word();
    logic [IN_W-1:0] w;
    w = '0;
    for (int k = 0; k < SYM_N; k++) w = (w << OUT_W) | IN_W'(k % 16);
    return w;
  endfunction

  function automatic logic [IN_W-1:0] fill_word(input logic [OUT_W-1:0] s);
    logic [IN_W-1:0] w;
    w = '0;
    for (int k = 0; k < SYM_N; k++) w = (w << OUT_W) | IN_W'(s);
    return w;
  endfunction

  // advance the reference model across one rising edge
  task automatic model_edge();
    logic [IN_W-1:0] w;
    if (rst) begin
      m_q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (m_busy && !bus.buf_full) begin
      m_done = 1'b0;
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (!m_busy && bus.data_valid) begin
        w = bus.data_in;
        for (int k = 0; k < SYM_N; k++) m_q.push_back(w[IN_W-1-OUT_W*k -: OUT_W]);
        m_busy  = 1'b1;
        acc_cyc = cyc;
        acc_cnt++;
      end
    end
  endtask

  // one clock: compare at the falling edge, update the model at the rising edge
  task automatic cycle();
    logic [OUT_W-1:0] exp_out;
    @(negedge clk);
    seen_done = (bus.done === 1'b1);
    if (chk_en) begin
      exp_out = m_busy ? m_q[0] : '0;
      chk("data_ready", 64'(bus.data_ready), 64'(!m_busy && !rst));
      chk("wr_en",      64'(bus.wr_en),      64'(m_busy && !bus.buf_full && !rst));
      chk("busy",       64'(bus.busy),       64'(m_busy));
      chk("done",       64'(bus.done),       64'(m_done));
      chk("data_out",   64'(bus.data_out),   64'(exp_out));
    end
    if (bus.wr_en === 1'b1) obs_wr++;
    if (bus.done === 1'b1) begin
      obs_done++;
      done_cyc = cyc;
    end
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  // offer one word, then apply the per-SHIFT-cycle stall mask until done
  task automatic run_word(input logic [IN_W-1:0] w, input logic [511:0] stall,
                          input int exp_lat, input string tag);
    int n;
    int a0;
    int wr0;
    a0 = acc_cnt;
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    bus.buf_full   = 1'b0;
    n = 0;
    while (acc_cnt == a0 && n < 20) begin
      cycle();
      n++;
    end
    chk({tag, "_accept"}, 64'(acc_cnt - a0), 64'd1);
    bus.data_valid = 1'b0;
    bus.data_in    = rand_word();
    wr0 = obs_wr;
    seen_done = 1'b0;
    n = 1;
    while (!seen_done && n < 400) begin
      bus.buf_full = stall[n];
      cycle();
      n++;
    end
    bus.buf_full = 1'b0;
    chk({tag, "_writes"},  64'(obs_wr - wr0), 64'(SYM_N));
    chk({tag, "_latency"}, 64'(done_cyc - acc_cyc), 64'(exp_lat));
  endtask

  initial begin
    logic [511:0] mask;
    int n;
    int a0;
    int wr0;
    int d0;
    int first_acc;

    // 1: reset
    rst            = 1'b1;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.buf_full   = 1'b0;
    cycle();
    chk_en = 1'b1;
    cycle();
    chk("t1_ready_in_rst", 64'(bus.data_ready), 64'd0);
    chk("t1_wr_en_in_rst", 64'(bus.wr_en), 64'd0);
    chk("t1_busy_in_rst",  64'(bus.busy), 64'd0);
    chk("t1_done_in_rst",  64'(bus.done), 64'd0);
    rst = 1'b0;
    #1;
    chk("t1_ready_after", 64'(bus.data_ready), 64'd1);
    chk("t1_dout_after",  64'(bus.data_out), 64'd0);
    cycle();

    // 2: ramp word, no back-pressure
    run_word(ramp_word(), '0, SYM_N + 1, "t2");
    cycle();

    // 3: same word with stalls on SHIFT cycles 3-5 and 40
    mask = '0;
    mask[3] = 1'b1;
    mask[4] = 1'b1;
    mask[5] = 1'b1;
    mask[40] = 1'b1;
    run_word(ramp_word(), mask, SYM_N + 5, "t3");
    cycle();

    // 4: two words back-to-back with valid held high
    a0 = acc_cnt;
    bus.data_in    = fill_word(4'hA);
    bus.data_valid = 1'b1;
    n = 0;
    while (acc_cnt == a0 && n < 20) begin
      cycle();
      n++;
    end
    first_acc = acc_cyc;
    bus.data_in = fill_word(4'h5);
    wr0 = obs_wr;
    n = 0;
    while (acc_cnt < a0 + 2 && n < 100) begin
      cycle();
      n++;
    end
    chk("t4_second_accept", 64'(acc_cnt - a0), 64'd2);
    chk("t4_b2b_period",    64'(acc_cyc - first_acc), 64'(SYM_N + 1));
    chk("t4_first_writes",  64'(obs_wr - wr0), 64'(SYM_N));
    bus.data_valid = 1'b0;
    wr0 = obs_wr;
    seen_done = 1'b0;
    n = 0;
    while (!seen_done && n < 100) begin
      cycle();
      n++;
    end
    chk("t4_second_writes", 64'(obs_wr - wr0), 64'(SYM_N));

    // 5: reset after the 10th write of a word
    a0 = acc_cnt;
    bus.data_in    = rand_word();
    bus.data_valid = 1'b1;
    n = 0;
    while (acc_cnt == a0 && n < 20) begin
      cycle();
      n++;
    end
    bus.data_valid = 1'b0;
    wr0 = obs_wr;
    n = 0;
    while (obs_wr - wr0 < 10 && n < 100) begin
      cycle();
      n++;
    end
    chk("t5_writes_before_rst", 64'(obs_wr - wr0), 64'd10);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    d0 = obs_done;
    wr0 = obs_wr;
    repeat (80) cycle();
    chk("t5_no_done",   64'(obs_done - d0), 64'd0);
    chk("t5_no_writes", 64'(obs_wr - wr0), 64'd0);
    chk("t5_ready",     64'(bus.data_ready), 64'd1);
    run_word(ramp_word(), '0, SYM_N + 1, "t5_restart");
    cycle();

    // 6: FIFO full for 200 cycles after accept
    a0 = acc_cnt;
    bus.data_in    = ramp_word();
    bus.data_valid = 1'b1;
    bus.buf_full   = 1'b1;
    n = 0;
    while (acc_cnt == a0 && n < 20) begin
      cycle();
      n++;
    end
    bus.data_valid = 1'b0;
    wr0 = obs_wr;
    repeat (200) cycle();
    chk("t6_stalled_writes", 64'(obs_wr - wr0), 64'd0);
    chk("t6_busy",           64'(bus.busy), 64'd1);
    bus.buf_full = 1'b0;
    seen_done = 1'b0;
    n = 0;
    while (!seen_done && n < 100) begin
      cycle();
      n++;
    end
    chk("t6_writes_after", 64'(obs_wr - wr0), 64'(SYM_N));

    // random phase
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.data_valid = $urandom_range(0, 1) == 1;
      bus.buf_full   = ($urandom_range(0, 3) == 0);
      bus.data_in    = rand_word();
      cycle();
    end
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    bus.buf_full   = 1'b0;
    repeat (SYM_N + 5) cycle();
    chk("final_idle", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
